// File: rtl/button_pulser_if.sv
// Button pulser bus: raw button pads in, arbitrated pulses and debounced levels out.
interface button_pulser_if;
    logic       btn_set;
    logic       btn_up;
    logic       btn_down;
    logic       pulsed_set;
    logic       pulsed_up;
    logic       pulsed_down;
    logic [2:0] held;

    // Drives the raw buttons and observes the pulses (stimulus or upstream pads).
    modport master (
        output btn_set, btn_up, btn_down,
        input  pulsed_set, pulsed_up, pulsed_down, held
    );

    // The conditioner itself.
    modport slave (
        input  btn_set, btn_up, btn_down,
        output pulsed_set, pulsed_up, pulsed_down, held
    );
endinterface

// File: rtl/button_pulser.sv
// Button front end for the clock-setting keys (set, up, down).
// Each channel: two-flop synchroniser, debounce counter, press detect.
// Press requests are arbitrated set > up > down so at most one pulse fires
// per cycle; losing requests are dropped.
// Optional macro BUTTON_PULSER_AUTO_REPEAT_EN adds hold-to-repeat on up/down.
module button_pulser #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic            clk,
    input  logic            reset,
    button_pulser_if.slave  bus
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("button_pulser: DEBOUNCE_CYCLES must be >= 2, repeat timings >= 1");
    end

    // Channel order everywhere: bit 0 = set, bit 1 = up, bit 2 = down.
    logic [2:0]    raw;
    logic [2:0]    sync1_q;
    logic [2:0]    sync2_q;
    logic [2:0]    held_q;
    logic [2:0]    held_d;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic [2:0]    press;
    logic [2:0]    rep;
    logic [2:0]    req;
    logic [2:0]    pulse_q;
    logic [2:0]    pulse_d;

    assign raw = {bus.btn_down, bus.btn_up, bus.btn_set};

    // Debounce: count consecutive cycles the synchronised input disagrees
    // with the debounced level; any agreement restarts the count.
    always_comb begin
        held_d = held_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != held_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    held_d[i] = ~held_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // A rising debounced level is a press; releases are ignored.
    assign press = held_d & ~held_q;

`ifdef BUTTON_PULSER_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD) + 1;

    logic [RW-1:0] hold_q   [1:2];
    logic [RW-1:0] hold_d   [1:2];
    logic [RW-1:0] hold_nxt [1:2];

    // Hold timers for up/down: zero on the press edge, count while the key
    // stays down, fire at REPEAT_DELAY and then every REPEAT_PERIOD by
    // folding back to REPEAT_DELAY. Release clears the timer at once.
    always_comb begin
        rep = '0;
        for (int i = 1; i <= 2; i++) begin
            hold_d[i]   = '0;
            hold_nxt[i] = hold_q[i] + 1'b1;
            if (held_q[i] && held_d[i]) begin
                if (hold_nxt[i] == RW'(REPEAT_DELAY)) begin
                    rep[i]    = 1'b1;
                    hold_d[i] = hold_nxt[i];
                end else if (hold_nxt[i] == RW'(REPEAT_DELAY + REPEAT_PERIOD)) begin
                    rep[i]    = 1'b1;
                    hold_d[i] = RW'(REPEAT_DELAY);
                end else begin
                    hold_d[i] = hold_nxt[i];
                end
            end
        end
    end

    // Hold timer registers.
    always_ff @(posedge clk) begin
        for (int i = 1; i <= 2; i++) begin
            if (reset) begin
                hold_q[i] <= '0;
            end else begin
                hold_q[i] <= hold_d[i];
            end
        end
    end
`else
    assign rep = '0;
`endif

    assign req = press | rep;

    // Fixed priority set > up > down; the losers are simply discarded.
    always_comb begin
        pulse_d = 3'b000;
        if (req[0]) begin
            pulse_d[0] = 1'b1;
        end else if (req[1]) begin
            pulse_d[1] = 1'b1;
        end else if (req[2]) begin
            pulse_d[2] = 1'b1;
        end
    end

    // State registers: synchronisers, debounce counters, levels, pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            held_q  <= '0;
            pulse_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            held_q  <= held_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.pulsed_set  = pulse_q[0];
    assign bus.pulsed_up   = pulse_q[1];
    assign bus.pulsed_down = pulse_q[2];
    assign bus.held        = held_q;

endmodule

// File: tb/tb_button_pulser.sv
// Bench for button_pulser: directed scenarios plus random button traffic,
// checked every cycle against a history-based reference model.
module tb_button_pulser;

    localparam int DEB = 4;
    localparam int RD  = 8;
    localparam int RP  = 4;

    logic clk = 1'b0;
    logic reset;
    button_pulser_if bus ();

    button_pulser #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

`ifdef BUTTON_PULSER_AUTO_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    // ---------------- reference model ----------------
    // Keeps the raw samples per channel; the synchronised view of an edge is
    // the sample taken two edges earlier. A level flips once the last DEB
    // synchronised values all disagree with it and all came after the
    // previous flip (or reset).
    bit   rs [3][$];
    bit   hs [3][$];
    bit   lvl [3];
    int   lastflip [3];
    int   press_t [3];
    int   t = 0;
    logic [2:0] exp_pulse = 3'b000;
    logic [2:0] exp_held  = 3'b000;

    always @(posedge clk) begin
        bit raw [3];
        bit req [3];
        raw[0] = bus.btn_set;
        raw[1] = bus.btn_up;
        raw[2] = bus.btn_down;
        t = t + 1;
        if (reset) begin
            for (int c = 0; c < 3; c++) begin
                rs[c].delete();
                hs[c].delete();
                lvl[c] = 1'b0;
                lastflip[c] = t;
            end
            exp_pulse = 3'b000;
        end else begin
            for (int c = 0; c < 3; c++) begin
                bit s2;
                bit all_diff;
                bit was;
                s2 = (rs[c].size() >= 2) ? rs[c][rs[c].size()-2] : 1'b0;
                hs[c].push_back(s2);
                all_diff = (hs[c].size() >= DEB) && (t - lastflip[c] >= DEB);
                for (int k = 1; k <= DEB && all_diff; k++)
                    if (hs[c][hs[c].size()-k] == lvl[c]) all_diff = 1'b0;
                was = lvl[c];
                req[c] = 1'b0;
                if (all_diff) begin
                    lvl[c] = ~lvl[c];
                    lastflip[c] = t;
                end
                if (lvl[c] && !was) begin
                    req[c] = 1'b1;
                    press_t[c] = t;
                end else if (REPEAT_ON && c != 0 && lvl[c] && was) begin
                    int d;
                    d = t - press_t[c];
                    if (d == RD || (d > RD && (d - RD) % RP == 0)) req[c] = 1'b1;
                end
                rs[c].push_back(raw[c]);
                if (rs[c].size() > 4) void'(rs[c].pop_front());
                if (hs[c].size() > DEB + 2) void'(hs[c].pop_front());
            end
            exp_pulse = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
        end
        exp_held = {lvl[2], lvl[1], lvl[0]};
    end

    function automatic logic [2:0] dut_pulse();
        return {bus.pulsed_down, bus.pulsed_up, bus.pulsed_set};
    endfunction

    task automatic drive(input bit s, input bit u, input bit d);
        bus.btn_set  = s;
        bus.btn_up   = u;
        bus.btn_down = d;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(0, 0, 0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if (dut_pulse() !== 3'b000 || bus.held !== 3'b000) begin
            nerr++;
            $display("FAIL reset_state: pulses=%b held=%b, want 000/000", dut_pulse(), bus.held);
        end
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            nvec++;
            if (dut_pulse() !== 3'b000 || bus.held !== 3'b000) begin
                nerr++;
                $display("FAIL idle cyc%0d: pulses=%b held=%b, want 000/000", i, dut_pulse(), bus.held);
            end
        end
    endtask

    task automatic test_clean_press();
        int first = -1;
        int npulse = 0;
        drive(0, 1, 0);
        for (int i = 1; i <= 40; i++) begin
            if (i == 21) drive(0, 0, 0);
            @(posedge clk); #1;
            nvec++;
            if (dut_pulse() !== exp_pulse || bus.held !== exp_held) begin
                nerr++;
                $display("FAIL clean_press cyc%0d: pulses=%b held=%b, want %b/%b", i, dut_pulse(), bus.held, exp_pulse, exp_held);
            end
            if (bus.pulsed_up) begin
                npulse++;
                if (first < 0) first = i;
            end
        end
        nvec++;
        if (first != DEB + 2 || npulse != 1) begin
            nerr++;
            $display("FAIL clean_press_latency: first=%0d count=%0d, want %0d/1", first, npulse, DEB + 2);
        end
    endtask

    task automatic test_bounce();
        int npulse = 0;
        int first = -1;
        bit pat [4] = '{1, 0, 1, 0};
        for (int i = 0; i < 4; i++) begin
            drive(pat[i], 0, 0);
            @(posedge clk); #1;
            nvec++;
            if (dut_pulse() !== exp_pulse || bus.held[0] !== 1'b0) begin
                nerr++;
                $display("FAIL bounce_glitch cyc%0d: pulses=%b held=%b, want 000/xx0", i, dut_pulse(), bus.held);
            end
        end
        drive(1, 0, 0);
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk); #1;
            nvec++;
            if (dut_pulse() !== exp_pulse || bus.held !== exp_held) begin
                nerr++;
                $display("FAIL bounce cyc%0d: pulses=%b held=%b, want %b/%b", i, dut_pulse(), bus.held, exp_pulse, exp_held);
            end
            if (bus.pulsed_set) begin
                npulse++;
                if (first < 0) first = i;
            end
        end
        nvec++;
        if (npulse != 1 || first != DEB + 2) begin
            nerr++;
            $display("FAIL bounce_count: count=%0d first=%0d, want 1/%0d", npulse, first, DEB + 2);
        end
        drive(0, 0, 0);
        repeat (DEB + 4) @(posedge clk);
    endtask

    task automatic test_simultaneous();
        int nset = 0;
        int ndown = 0;
        drive(1, 0, 1);
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk); #1;
            nvec++;
            if (dut_pulse() !== exp_pulse || bus.held !== exp_held) begin
                nerr++;
                $display("FAIL simultaneous cyc%0d: pulses=%b held=%b, want %b/%b", i, dut_pulse(), bus.held, exp_pulse, exp_held);
            end
            nset  += bus.pulsed_set;
            ndown += bus.pulsed_down;
        end
        nvec++;
        if (nset != 1 || ndown != 0) begin
            nerr++;
            $display("FAIL simultaneous_arb: set=%0d down=%0d, want 1/0", nset, ndown);
        end
        drive(0, 0, 0);
        repeat (DEB + 4) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int first = -1;
        int early = 0;
        drive(0, 0, 1);
        // After 4 edges the down counter stands at 2.
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            early += bus.pulsed_down;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        nvec++;
        if (early != 0 || dut_pulse() !== 3'b000 || bus.held !== 3'b000) begin
            nerr++;
            $display("FAIL reset_mid_clear: early=%0d pulses=%b held=%b, want 0/000/000", early, dut_pulse(), bus.held);
        end
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            nvec++;
            if (dut_pulse() !== exp_pulse || bus.held !== exp_held) begin
                nerr++;
                $display("FAIL reset_mid cyc%0d: pulses=%b held=%b, want %b/%b", i, dut_pulse(), bus.held, exp_pulse, exp_held);
            end
            if (bus.pulsed_down && first < 0) first = i;
        end
        nvec++;
        if (first != DEB + 2) begin
            nerr++;
            $display("FAIL reset_mid_latency: first=%0d, want %0d", first, DEB + 2);
        end
        drive(0, 0, 0);
        repeat (DEB + 4) @(posedge clk);
    endtask

    task automatic test_repeat();
        int npulse = 0;
        int late = 0;
        int want = 1;
        int fall = 40 + DEB + 2;
        if (REPEAT_ON)
            for (int k = DEB + 2 + RD; k < fall; k += RP) want++;
        drive(0, 1, 0);
        for (int i = 1; i <= 70; i++) begin
            if (i == 41) drive(0, 0, 0);
            @(posedge clk); #1;
            nvec++;
            if (dut_pulse() !== exp_pulse || bus.held !== exp_held) begin
                nerr++;
                $display("FAIL repeat cyc%0d: pulses=%b held=%b, want %b/%b", i, dut_pulse(), bus.held, exp_pulse, exp_held);
            end
            npulse += bus.pulsed_up;
            if (i >= fall) late += bus.pulsed_up;
        end
        nvec++;
        if (npulse != want || late != 0) begin
            nerr++;
            $display("FAIL repeat_count: count=%0d after_release=%0d, want %0d/0", npulse, late, want);
        end
    endtask

    task automatic test_random();
        bit s = 0, u = 0, d = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) s = ~s;
            if ($urandom_range(0, 7) == 0) u = ~u;
            if ($urandom_range(0, 7) == 0) d = ~d;
            drive(s, u, d);
            reset = ($urandom_range(0, 299) == 0);
            @(posedge clk); #1;
            nvec++;
            if (dut_pulse() !== exp_pulse || bus.held !== exp_held || $countones(dut_pulse()) > 1) begin
                nerr++;
                $display("FAIL random cyc%0d: pulses=%b held=%b, want %b/%b", i, dut_pulse(), bus.held, exp_pulse, exp_held);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0);
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_repeat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/button_pulser.md
Name: button_pulser

Overview:
- Front-end conditioner for the three clock-setting push buttons (set, up, down).
- Per button: synchronises the raw pad input, debounces it, and emits a single-cycle pulse on each debounced press.
- Its outputs drive the pulsed_set / pulsed_up / pulsed_down inputs of the clock/display-mode logic.
- Arbitration guarantees at most one pulse per cycle, so simultaneous presses cannot trigger both a mode change and an edit.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronised cycles an input must differ from its debounced level before that level flips (>=2).
- REPEAT_DELAY, 8, held cycles after a press pulse before the first auto-repeat pulse (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 4, cycles between successive auto-repeat pulses (AUTO_REPEAT_EN only).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_set  input  1  raw asynchronous set button, active-high.
- btn_up  input  1  raw asynchronous up button, active-high.
- btn_down  input  1  raw asynchronous down button, active-high.
- pulsed_set  output  1  one-cycle set pulse.
- pulsed_up  output  1  one-cycle up pulse.
- pulsed_down  output  1  one-cycle down pulse.
- held  output  3  debounced levels {down, up, set}.

Behaviour:
- Reset:
  - Synchronous and active-high: on a clk edge with reset=1, all sync flops, debounced levels, counters and outputs go to 0.
  - pulsed_* = 0 and held = 3'b000 in the cycle after reset is sampled.
  - Reset mid-debounce or mid-hold discards all progress.
  - A button still held when reset deasserts must re-qualify (full debounce) and then produces exactly one pulse.
- Synchroniser: per channel, two flops; sync2 is the second stage.
- Debounce, per channel:
  - Counter width clog2(DEBOUNCE_CYCLES)+1.
  - If sync2 == held[i], counter clears to 0.
  - Otherwise the counter increments; when it would reach DEBOUNCE_CYCLES, held[i] toggles and the counter clears.
  - Any bounce (sync2 returning to held[i]) restarts the count from 0.
- Press detect: a 0->1 transition of held[i] raises a request in the same edge.
  - Latency from the first clk edge sampling raw=1 to pulse high = DEBOUNCE_CYCLES+2 cycles.
  - Pulse width is exactly 1 cycle.
- Release: a 1->0 transition of held[i] produces no pulse.
- Arbitration:
  - If more than one request is raised in the same cycle, priority is set > up > down.
  - Lower-priority requests in that cycle are dropped, not queued.
- Outputs are registered. pulsed_set, pulsed_up and pulsed_down are mutually exclusive in every cycle.
- Inputs are treated as independent asynchronous signals; no relation between buttons is assumed.

Optional Feature:
- Macro: BUTTON_PULSER_AUTO_REPEAT_EN.
- Defined, for up/down only (set never repeats):
  - A per-channel hold counter starts at 0 on the press pulse.
  - While held[i] remains 1, the first repeat pulse is requested REPEAT_DELAY cycles after the press pulse, then one every REPEAT_PERIOD cycles.
  - Repeat requests go through the same arbitration.
  - Release (held[i]=0) or reset clears the hold counter immediately; no further repeats.
  - If up and down are both held, up wins each collision and the lost down repeat is dropped; down's repeat schedule continues unchanged.
- Undefined: hold counters are absent; exactly one pulse per debounced press regardless of hold time.

Test Plan:
- Reset, no buttons pressed: all outputs 0 and held=000 for 50 cycles.
- Clean press: btn_up=1 from cycle 10, held for 20 cycles (DEBOUNCE_CYCLES=4) -> pulsed_up=1 only at cycle 16; held[1]=1 from cycle 16; no pulse on release.
- Bounce: btn_set toggles 1,0,1,0 each cycle, then stays 1 -> exactly one pulsed_set, 6 cycles after the final rising sample; held[0] never glitches high during the bounce.
- Simultaneous press: btn_set and btn_down rise on the same edge -> single pulsed_set cycle; pulsed_down never asserts for this press.
- Reset mid-operation: btn_down held, reset asserted for 1 cycle at the debounce count of 2 -> no pulse before reset; one pulsed_down exactly 6 cycles after reset deasserts.
- BUTTON_PULSER_AUTO_REPEAT_EN: hold btn_up 40 cycles, REPEAT_DELAY=8, REPEAT_PERIOD=4 -> pulses at press P, P+8, P+12, P+16, and so on until release; none after release. With the macro undefined, only the pulse at P.
